lam_unit: RTL and testbench
===========================

LAM_UNIT -- requirements
Module: lam_unit

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: lam_new  input  1  load-start strobe from decoder.
REQ-004 SHALL provide: lam_control  input  9  {is_store[8], funct3[7:5], reg_idx[4:0]}; reg_idx = rd for loads, rs2 for stores.
REQ-005 SHALL provide: addr  input  32  effective address from ALU (rs1 + imm).
REQ-006 SHALL provide: store_data  input  32  rs2 value from register bank.
REQ-007 SHALL provide: mem_req, mem_we  output  1 each  memory request / write-enable.
REQ-008 SHALL provide: mem_addr  output  32  word-aligned address; mem_wdata  output  32; mem_wstrb  output  4.
REQ-009 SHALL provide: mem_ready  input  1  memory accept/complete; mem_rdata  input  32  read data, valid when mem_ready=1.
REQ-010 SHALL provide: wb_en  output  1; wb_sel  output  5; wb_data  output  32  register-bank writeback port.
REQ-011 SHALL provide: busy  output  1  pipeline stall; err  output  1  one-cycle misaligned/illegal pulse.

Function
REQ-012 Start condition SHALL be (lam_new=1 OR lam_control[8]=1) sampled in IDLE; addr, store_data, lam_control are captured into internal registers at that edge.
REQ-013 FSM states SHALL be IDLE, REQ, WB; IDLE->REQ on legal start; REQ->WB on mem_ready=1 for loads; REQ->IDLE on mem_ready=1 for stores; WB->IDLE unconditionally.
REQ-014 In REQ: mem_req=1, mem_we=is_store, mem_addr={addr[31:2],2'b00}; all held stable until the edge where mem_ready=1.
REQ-015 mem_req, mem_we, mem_wstrb SHALL be 0 in IDLE and WB.
REQ-016 Stores: SB(000) wstrb=4'b0001<<addr[1:0], wdata={4{byte}}; SH(001) wstrb=0011 (addr[1]=0) or 1100 (addr[1]=1), wdata={2{half}}; SW(010) wstrb=1111, wdata=store_data.
REQ-017 Loads: lane chosen by addr[1:0]; LB(000)/LH(001) sign-extend; LBU(100)/LHU(101) zero-extend; LW(010) pass-through; result registered on the mem_ready edge.
REQ-018 In WB: wb_en=1 for exactly one cycle, wb_sel=rd, wb_data=extended result; wb_en SHALL be 0 when rd=0 (FSM still passes through WB).
REQ-019 busy SHALL be 1 in REQ and WB, 0 in IDLE; start strobes while busy=1 are ignored (upstream holds instruction).
REQ-020 Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or illegal funct3 (loads 011/110/111; stores >=011): no mem_req, err=1 for one cycle in the cycle after start, FSM stays IDLE, no writeback.
REQ-021 Minimum latency: load start edge N -> mem_req in cycle N+1 -> wb_en in cycle after mem_ready edge (3 cycles total with mem_ready=1 immediately); store 2 cycles.
REQ-022 mem_ready while in IDLE or WB SHALL be ignored.

Reset
REQ-023 On rst_n=0 SHALL immediately (asynchronously) force state IDLE and all outputs to 0, abandoning any in-flight transaction without writeback.
REQ-024 After rst_n deasserts, first start SHALL be accepted on the next rising edge.

Verification
REQ-025 LB addr=0x103, mem_rdata=0x80FF_0000, mem_ready=1 at first REQ cycle -> mem_addr=0x100, wb_data=0xFFFFFF80, wb_sel=rd, wb_en one cycle.
REQ-026 LHU addr=0x202, mem_rdata=0x8001_1234 -> wb_data=0x0000_8001; LH same -> 0xFFFF_8001.
REQ-027 SB addr=0x41, store_data=0x0000_00AB -> mem_we=1, wstrb=0010, wdata=0xABABABAB, no wb_en, busy drops after ready.
REQ-028 SW addr=0x102 -> err=1 one cycle, mem_req never asserted, busy stays 0.
REQ-029 LW with mem_ready held 0 for 5 cycles -> mem_req/mem_addr stable 5 cycles, busy=1; new start during wait ignored; completes when ready=1.
REQ-030 rst_n pulled low in REQ -> mem_req=0 and busy=0 same cycle, no wb_en afterwards.

Source files
------------

// File: rtl/lam_unit.sv
// lam_unit: load/store unit for a single-issue core.
//   Accepts one load or store from the decoder, issues a single word-aligned
//   memory request, and for loads writes the lane-extracted, extended result
//   back to the register bank.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   lam_new             load-start strobe from decoder
//   lam_control[8:0]    {is_store, funct3[2:0], reg_idx[4:0]} (rd for loads, rs2 for stores)
//   addr[31:0]          effective address (rs1 + imm)
//   store_data[31:0]    rs2 value for stores
//   mem_req, mem_we     memory request / write enable
//   mem_addr[31:0]      word-aligned request address
//   mem_wdata[31:0]     lane-replicated store data
//   mem_wstrb[3:0]      byte write strobes
//   mem_ready           memory accept/complete
//   mem_rdata[31:0]     read data, valid with mem_ready
//   wb_en, wb_sel, wb_data  register-bank writeback port
//   busy                stall request to the pipeline
//   err                 one-cycle pulse on misaligned or illegal access
module lam_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        lam_new,
   input  logic [8:0]  lam_control,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        wb_en,
   output logic [4:0]  wb_sel,
   output logic [31:0] wb_data,
   output logic        busy,
   output logic        err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WB   = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [8:0]  ctrl_q;
   logic [31:0] addr_q;
   logic [31:0] sdata_q;
   logic [31:0] result_q, result_d;
   logic        err_q, err_d;

   logic        start;
   logic        bad_funct;
   logic        misaligned;
   logic [2:0]  in_funct;

   logic        is_store_q;
   logic [2:0]  funct_q;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   assign start    = lam_new | lam_control[8];
   assign in_funct = lam_control[7:5];

   // Legal encodings: loads 000/001/010/100/101, stores 000/001/010.
   always_comb begin
      bad_funct = 1'b0;
      if (lam_control[8]) begin
         bad_funct = (in_funct >= 3'b011);
      end else begin
         bad_funct = (in_funct == 3'b011) || (in_funct == 3'b110) ||
                     (in_funct == 3'b111);
      end
   end

   // funct3[1:0] gives the access size for both loads and stores.
   assign misaligned = ((in_funct[1:0] == 2'b01) && addr[0]) ||
                       ((in_funct[1:0] == 2'b10) && (addr[1:0] != 2'b00));

   assign is_store_q = ctrl_q[8];
   assign funct_q    = ctrl_q[7:5];

   // Load lane extraction from the captured byte offset.
   always_comb begin
      ld_byte = mem_rdata[7:0];
      case (addr_q[1:0])
         2'd0:    ld_byte = mem_rdata[7:0];
         2'd1:    ld_byte = mem_rdata[15:8];
         2'd2:    ld_byte = mem_rdata[23:16];
         default: ld_byte = mem_rdata[31:24];
      endcase
      ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      ld_ext  = mem_rdata;
      case (funct_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {24'd0, ld_byte};
         3'b101:  ld_ext = {16'd0, ld_half};
         default: ld_ext = mem_rdata;
      endcase
   end

   // Store strobes are only driven while a store request is outstanding.
   always_comb begin
      mem_wstrb = '0;
      mem_wdata = sdata_q;
      case (funct_q[1:0])
         2'b00: begin
            mem_wdata = {4{sdata_q[7:0]}};
            if (state_q == S_REQ && is_store_q) mem_wstrb = 4'b0001 << addr_q[1:0];
         end
         2'b01: begin
            mem_wdata = {2{sdata_q[15:0]}};
            if (state_q == S_REQ && is_store_q) mem_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            mem_wdata = sdata_q;
            if (state_q == S_REQ && is_store_q) mem_wstrb = 4'b1111;
         end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      err_d    = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      busy     = 1'b0;
      wb_en    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (bad_funct || misaligned) err_d   = 1'b1;
               else                          state_d = S_REQ;
            end
         end
         S_REQ: begin
            mem_req = 1'b1;
            mem_we  = is_store_q;
            busy    = 1'b1;
            if (mem_ready) begin
               if (is_store_q) begin
                  state_d = S_IDLE;
               end else begin
                  state_d  = S_WB;
                  result_d = ld_ext;
               end
            end
         end
         S_WB: begin
            busy    = 1'b1;
            wb_en   = (ctrl_q[4:0] != 5'd0);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         ctrl_q   <= '0;
         addr_q   <= '0;
         sdata_q  <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         err_q    <= err_d;
         if (state_q == S_IDLE && start) begin
            ctrl_q  <= lam_control;
            addr_q  <= addr;
            sdata_q <= store_data;
         end
      end
   end

   assign mem_addr = {addr_q[31:2], 2'b00};
   assign wb_sel   = ctrl_q[4:0];
   assign wb_data  = result_q;
   assign err      = err_q;

endmodule

// File: tb/tb_lam_unit.sv
module tb_lam_unit;

   logic        clk;
   logic        rst_n;
   logic        lam_new;
   logic [8:0]  lam_control;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        wb_en;
   logic [4:0]  wb_sel;
   logic [31:0] wb_data;
   logic        busy;
   logic        err;

   int unsigned n_pass;
   int unsigned n_total;

   lam_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .lam_new     (lam_new),
      .lam_control (lam_control),
      .addr        (addr),
      .store_data  (store_data),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wstrb   (mem_wstrb),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .wb_en       (wb_en),
      .wb_sel      (wb_sel),
      .wb_data     (wb_data),
      .busy        (busy),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Advance one clock; sample 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_pass      = 0;
      n_total     = 0;
      rst_n       = 1'b0;
      lam_new     = 1'b0;
      lam_control = '0;
      addr        = '0;
      store_data  = '0;
      mem_ready   = 1'b0;
      mem_rdata   = '0;

      // Reset state
      #12;
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_busy",    {31'd0, busy},    32'd0);
      chk("rst_wb_en",   {31'd0, wb_en},   32'd0);
      chk("rst_err",     {31'd0, err},     32'd0);
      chk("rst_wbdata",  wb_data,          32'd0);
      #5 rst_n = 1'b1;
      step();

      // LB addr 0x103, rd=7, ready already high in IDLE (ignored there)
      lam_new = 1'b1; lam_control = {1'b0, 3'b000, 5'd7}; addr = 32'h103;
      mem_ready = 1'b1; mem_rdata = 32'h80FF_0000;
      step();
      lam_new = 1'b0;
      chk("lb_req",    {31'd0, mem_req}, 32'd1);
      chk("lb_we",     {31'd0, mem_we},  32'd0);
      chk("lb_addr",   mem_addr,         32'h100);
      chk("lb_strb",   {28'd0, mem_wstrb}, 32'd0);
      chk("lb_busy",   {31'd0, busy},    32'd1);
      step();
      chk("lb_wben",   {31'd0, wb_en},   32'd1);
      chk("lb_wbsel",  {27'd0, wb_sel},  32'd7);
      chk("lb_wbdata", wb_data,          32'hFFFF_FF80);
      chk("lb_wb_req", {31'd0, mem_req}, 32'd0);
      chk("lb_wb_busy",{31'd0, busy},    32'd1);
      step();
      chk("lb_done_wben", {31'd0, wb_en}, 32'd0);
      chk("lb_done_busy", {31'd0, busy},  32'd0);

      // LHU addr 0x202
      lam_new = 1'b1; lam_control = {1'b0, 3'b101, 5'd4}; addr = 32'h202;
      mem_rdata = 32'h8001_1234;
      step();
      lam_new = 1'b0;
      chk("lhu_addr", mem_addr, 32'h200);
      step();
      chk("lhu_wbdata", wb_data, 32'h0000_8001);
      step();

      // LH same address
      lam_new = 1'b1; lam_control = {1'b0, 3'b001, 5'd4}; addr = 32'h202;
      step();
      lam_new = 1'b0;
      step();
      chk("lh_wbdata", wb_data, 32'hFFFF_8001);
      chk("lh_wben",   {31'd0, wb_en}, 32'd1);
      step();

      // SB addr 0x41: is_store alone starts the transaction
      lam_control = {1'b1, 3'b000, 5'd5}; addr = 32'h41; store_data = 32'h0000_00AB;
      step();
      lam_control = '0;
      chk("sb_req",   {31'd0, mem_req}, 32'd1);
      chk("sb_we",    {31'd0, mem_we},  32'd1);
      chk("sb_strb",  {28'd0, mem_wstrb}, 32'b0010);
      chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
      chk("sb_addr",  mem_addr,  32'h40);
      step();
      chk("sb_busy",  {31'd0, busy},  32'd0);
      chk("sb_wben",  {31'd0, wb_en}, 32'd0);
      chk("sb_req_off", {31'd0, mem_req}, 32'd0);

      // SH addr 0x42 -> upper half
      lam_control = {1'b1, 3'b001, 5'd6}; addr = 32'h42; store_data = 32'h1234_CDEF;
      step();
      lam_control = '0;
      chk("sh_strb",  {28'd0, mem_wstrb}, 32'b1100);
      chk("sh_wdata", mem_wdata, 32'hCDEF_CDEF);
      step();

      // SW misaligned addr 0x102
      lam_control = {1'b1, 3'b010, 5'd2}; addr = 32'h102; store_data = 32'h5555_5555;
      step();
      lam_control = '0;
      chk("sw_mis_err",  {31'd0, err},     32'd1);
      chk("sw_mis_req",  {31'd0, mem_req}, 32'd0);
      chk("sw_mis_busy", {31'd0, busy},    32'd0);
      step();
      chk("sw_mis_err_clr", {31'd0, err},     32'd0);
      chk("sw_mis_req2",    {31'd0, mem_req}, 32'd0);

      // Illegal load funct3 011
      lam_new = 1'b1; lam_control = {1'b0, 3'b011, 5'd3}; addr = 32'h0;
      step();
      lam_new = 1'b0;
      chk("ld_ill_err",  {31'd0, err},  32'd1);
      chk("ld_ill_busy", {31'd0, busy}, 32'd0);
      step();
      chk("ld_ill_err_clr", {31'd0, err}, 32'd0);

      // LW with memory stalled 5 cycles; a second start is ignored
      mem_ready = 1'b0;
      lam_new = 1'b1; lam_control = {1'b0, 3'b010, 5'd3}; addr = 32'h1000;
      step();
      lam_control = {1'b0, 3'b010, 5'd9}; addr = 32'h2000;
      for (int i = 0; i < 5; i++) begin
         chk("lw_wait_req",  {31'd0, mem_req}, 32'd1);
         chk("lw_wait_addr", mem_addr,         32'h1000);
         chk("lw_wait_busy", {31'd0, busy},    32'd1);
         if (i < 4) step();
      end
      lam_new = 1'b0; lam_control = '0;
      mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      step();
      mem_ready = 1'b0;
      chk("lw_wbdata", wb_data,         32'hDEAD_BEEF);
      chk("lw_wbsel",  {27'd0, wb_sel}, 32'd3);
      chk("lw_wben",   {31'd0, wb_en},  32'd1);
      step();
      chk("lw_idle_busy", {31'd0, busy}, 32'd0);

      // LW to x0: passes through WB without writeback
      lam_new = 1'b1; lam_control = {1'b0, 3'b010, 5'd0}; addr = 32'h8;
      mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
      step();
      lam_new = 1'b0;
      step();
      chk("x0_wben", {31'd0, wb_en}, 32'd0);
      chk("x0_busy", {31'd0, busy},  32'd1);
      step();
      mem_ready = 1'b0;

      // Reset while in REQ
      lam_new = 1'b1; lam_control = {1'b0, 3'b010, 5'd8}; addr = 32'h300;
      step();
      lam_new = 1'b0;
      chk("rreq_req", {31'd0, mem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rreq_req_off",  {31'd0, mem_req}, 32'd0);
      chk("rreq_busy_off", {31'd0, busy},    32'd0);
      mem_ready = 1'b1;
      #3 rst_n = 1'b1;
      // first start after release is accepted on the next edge
      lam_new = 1'b1; lam_control = {1'b0, 3'b100, 5'd9}; addr = 32'h1;
      mem_rdata = 32'h0000_AB00;
      step();
      lam_new = 1'b0;
      chk("post_rst_req",  {31'd0, mem_req}, 32'd1);
      chk("post_rst_wben", {31'd0, wb_en},   32'd0);
      step();
      chk("lbu_wbdata", wb_data,         32'h0000_00AB);
      chk("lbu_wbsel",  {27'd0, wb_sel}, 32'd9);
      step();
      chk("lbu_idle_wben", {31'd0, wb_en}, 32'd0);
      mem_ready = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
